// File: rtl/fir_cfg_pkg.sv
// Shared definitions for the FIR AXI4-Lite configuration block: region codes,
// ap_ctrl layout, FSM states and the ap_ctrl reset value.
package fir_cfg_pkg;

  localparam int unsigned REGION_W = 4;

  localparam logic [REGION_W-1:0] REG_CTRL   = 4'h0;
  localparam logic [REGION_W-1:0] REG_TAPNUM = 4'h1;
  localparam logic [REGION_W-1:0] REG_DLEN   = 4'h2;
  localparam logic [REGION_W-1:0] REG_TAP    = 4'h3;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_DONE_BIT  = 1;
  localparam int unsigned CTRL_IDLE_BIT  = 2;

  typedef struct packed {
    logic idle;
    logic done;
    logic start;
  } ap_ctrl_t;

  localparam ap_ctrl_t AP_CTRL_RST = '{idle: 1'b1, done: 1'b0, start: 1'b0};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ACK  = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_DATA = 3'd4
  } cfg_state_e;

endpackage

// File: rtl/fir_axil_cfg.sv
// AXI4-Lite responder and config registers for the FIR core; owns the tap RAM
// port while idle. Optional tap index bounds check: FIR_CFG_BOUNDS_CHECK_EN.
module fir_axil_cfg
  import fir_cfg_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH   = 32,
  parameter int unsigned pDATA_WIDTH   = 32,
  parameter int unsigned TAP_NUM       = 11,
  parameter int unsigned TAP_NUM_WIDTH = 10
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       in_s_awvalid,
  input  logic [pADDR_WIDTH-1:0]     in_s_awaddr,
  output logic                       out_s_awready,
  input  logic                       in_s_wvalid,
  input  logic [pDATA_WIDTH-1:0]     in_s_wdata,
  output logic                       out_s_wready,
  input  logic                       in_s_arvalid,
  input  logic [pADDR_WIDTH-1:0]     in_s_araddr,
  output logic                       out_s_arready,
  output logic                       out_s_rvalid,
  output logic [pDATA_WIDTH-1:0]     out_s_rdata,
  input  logic                       in_s_rready,
  output logic [pDATA_WIDTH/8-1:0]   out_tap_WE,
  output logic                       out_tap_EN,
  output logic [pDATA_WIDTH-1:0]     out_tap_Di,
  output logic [TAP_NUM_WIDTH-1:0]   out_tap_A,
  input  logic [pDATA_WIDTH-1:0]     in_tap_Do,
  input  logic                       in_core_tap_EN,
  input  logic [TAP_NUM_WIDTH-1:0]   in_core_tap_A,
  input  logic                       in_core_done,
  output logic                       out_ap_start,
  output logic [pDATA_WIDTH-1:0]     out_tap_num,
  output logic [pDATA_WIDTH-1:0]     out_data_length
);

  localparam int unsigned WE_W = pDATA_WIDTH / 8;

  cfg_state_e state_q, state_d;

  logic [REGION_W-1:0]      aw_region, ar_region, region_q;
  logic [TAP_NUM_WIDTH-1:0] aw_idx, ar_idx;
  logic                     aw_in_bounds, ar_in_bounds;
  logic                     aw_tap_ok, ar_tap_ok;
  logic [pDATA_WIDTH-1:0]   wdata_q;
  logic                     tap_rd_ok_q;
  ap_ctrl_t                 ctrl_q;
  logic [pDATA_WIDTH-1:0]   tap_num_q, data_length_q;
  logic [pDATA_WIDTH-1:0]   reg_rdata;

  logic                     awready_d, wready_d, arready_d, rvalid_d;
  logic                     host_en_d, host_en_q;
  logic [WE_W-1:0]          host_we_d, host_we_q;
  logic [TAP_NUM_WIDTH-1:0] host_a_d, host_a_q;
  logic [pDATA_WIDTH-1:0]   host_di_d, host_di_q;

  logic                     wr_commit, rd_done, start_req;

  // Address fields: region in the top nibble, tap word index in the low bits
  assign aw_region = in_s_awaddr[pADDR_WIDTH-1 -: REGION_W];
  assign ar_region = in_s_araddr[pADDR_WIDTH-1 -: REGION_W];
  assign aw_idx    = in_s_awaddr[TAP_NUM_WIDTH-1:0];
  assign ar_idx    = in_s_araddr[TAP_NUM_WIDTH-1:0];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{in_s_awaddr[pADDR_WIDTH-REGION_W-1:TAP_NUM_WIDTH],
                              in_s_araddr[pADDR_WIDTH-REGION_W-1:TAP_NUM_WIDTH]};

`ifdef FIR_CFG_BOUNDS_CHECK_EN
  assign aw_in_bounds = (32'(aw_idx) < 32'(TAP_NUM)) && (pDATA_WIDTH'(aw_idx) < tap_num_q);
  assign ar_in_bounds = (32'(ar_idx) < 32'(TAP_NUM)) && (pDATA_WIDTH'(ar_idx) < tap_num_q);
`else
  localparam int unsigned TAP_DEPTH_UNUSED = TAP_NUM;
  assign aw_in_bounds = 1'b1;
  assign ar_in_bounds = 1'b1;
`endif

  // Host may touch the tap RAM only while the core is idle
  assign aw_tap_ok = (aw_region == REG_TAP) && ctrl_q.idle && aw_in_bounds;
  assign ar_tap_ok = (ar_region == REG_TAP) && ctrl_q.idle && ar_in_bounds;

  assign wr_commit = (state_q == ST_WR_ACK);
  assign rd_done   = (state_q == ST_RD_DATA) && in_s_rready;
  assign start_req = wr_commit && (region_q == REG_CTRL) && wdata_q[CTRL_START_BIT] && ctrl_q.idle;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a write beats a simultaneous read
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_s_awvalid && in_s_wvalid) state_d = ST_WR_ACK;
        else if (in_s_arvalid)           state_d = ST_RD_ADDR;
      end
      ST_WR_ACK:  state_d = ST_IDLE;
      ST_RD_ADDR: state_d = (region_q == REG_TAP) ? ST_RD_WAIT : ST_RD_DATA;
      ST_RD_WAIT: state_d = ST_RD_DATA;
      ST_RD_DATA: if (in_s_rready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered handshake and host tap port
  always_comb begin
    awready_d = (state_d == ST_WR_ACK);
    wready_d  = (state_d == ST_WR_ACK);
    arready_d = (state_d == ST_RD_ADDR);
    rvalid_d  = (state_d == ST_RD_DATA);
    host_en_d = 1'b0;
    host_we_d = '0;
    host_a_d  = host_a_q;
    host_di_d = host_di_q;
    if (state_q == ST_IDLE && state_d == ST_WR_ACK && aw_tap_ok) begin
      host_en_d = 1'b1;
      host_we_d = '1;
      host_a_d  = aw_idx;
      host_di_d = in_s_wdata;
    end else if (state_q == ST_IDLE && state_d == ST_RD_ADDR && ar_tap_ok) begin
      host_en_d = 1'b1;
      host_a_d  = ar_idx;
    end
  end

  // Handshake outputs, host tap port and captured request
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_s_awready <= 1'b0;
      out_s_wready  <= 1'b0;
      out_s_arready <= 1'b0;
      out_s_rvalid  <= 1'b0;
      host_en_q     <= 1'b0;
      host_we_q     <= '0;
      host_a_q      <= '0;
      host_di_q     <= '0;
      region_q      <= '0;
      wdata_q       <= '0;
      tap_rd_ok_q   <= 1'b0;
    end else begin
      out_s_awready <= awready_d;
      out_s_wready  <= wready_d;
      out_s_arready <= arready_d;
      out_s_rvalid  <= rvalid_d;
      host_en_q     <= host_en_d;
      host_we_q     <= host_we_d;
      host_a_q      <= host_a_d;
      host_di_q     <= host_di_d;
      if (state_q == ST_IDLE) begin
        if (state_d == ST_WR_ACK) begin
          region_q <= aw_region;
          wdata_q  <= in_s_wdata;
        end else if (state_d == ST_RD_ADDR) begin
          region_q    <= ar_region;
          tap_rd_ok_q <= ar_tap_ok;
        end
      end
    end
  end

  // Register read mux
  always_comb begin
    reg_rdata = '0;
    case (region_q)
      REG_CTRL: begin
        reg_rdata[CTRL_START_BIT] = ctrl_q.start;
        reg_rdata[CTRL_DONE_BIT]  = ctrl_q.done;
        reg_rdata[CTRL_IDLE_BIT]  = ctrl_q.idle;
      end
      REG_TAPNUM: reg_rdata = tap_num_q;
      REG_DLEN:   reg_rdata = data_length_q;
      default:    reg_rdata = '0;
    endcase
  end

  // Read data: registers load straight from RD_ADDR, taps after the RAM wait
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_s_rdata <= '0;
    end else if (state_q == ST_RD_ADDR && state_d == ST_RD_DATA) begin
      out_s_rdata <= reg_rdata;
    end else if (state_q == ST_RD_WAIT) begin
      out_s_rdata <= tap_rd_ok_q ? in_tap_Do : '0;
    end
  end

  // Config registers and ap_ctrl; core_done wins over a same-cycle start
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tap_num_q     <= '0;
      data_length_q <= '0;
      ctrl_q        <= AP_CTRL_RST;
      out_ap_start  <= 1'b0;
    end else begin
      out_ap_start <= 1'b0;
      ctrl_q.start <= 1'b0;
      if (wr_commit && ctrl_q.idle) begin
        if (region_q == REG_TAPNUM) tap_num_q     <= wdata_q;
        if (region_q == REG_DLEN)   data_length_q <= wdata_q;
      end
      if (rd_done && region_q == REG_CTRL) ctrl_q.done <= 1'b0;
      if (in_core_done) begin
        ctrl_q.done <= 1'b1;
        ctrl_q.idle <= 1'b1;
      end else if (start_req) begin
        ctrl_q.start <= 1'b1;
        ctrl_q.idle  <= 1'b0;
        ctrl_q.done  <= 1'b0;
        out_ap_start <= 1'b1;
      end
    end
  end

  // Tap RAM port: host while idle, core while running
  always_comb begin
    if (ctrl_q.idle) begin
      out_tap_EN = host_en_q;
      out_tap_WE = host_we_q;
      out_tap_A  = host_a_q;
    end else begin
      out_tap_EN = in_core_tap_EN;
      out_tap_WE = '0;
      out_tap_A  = in_core_tap_A;
    end
  end

  assign out_tap_Di      = host_di_q;
  assign out_tap_num     = tap_num_q;
  assign out_data_length = data_length_q;

endmodule

// File: tb/tb_fir_axil_cfg.sv
// Self-checking bench for fir_axil_cfg: directed checks plus randomized
// register/tap traffic against a behavioural model of the config space.
`timescale 1ns/1ps
module tb_fir_axil_cfg;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TN = 11;
  localparam int unsigned TNW = 10;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic           in_s_awvalid = 1'b0;
  logic [AW-1:0]  in_s_awaddr = '0;
  logic           out_s_awready;
  logic           in_s_wvalid = 1'b0;
  logic [DW-1:0]  in_s_wdata = '0;
  logic           out_s_wready;
  logic           in_s_arvalid = 1'b0;
  logic [AW-1:0]  in_s_araddr = '0;
  logic           out_s_arready;
  logic           out_s_rvalid;
  logic [DW-1:0]  out_s_rdata;
  logic           in_s_rready = 1'b0;
  logic [DW/8-1:0] out_tap_WE;
  logic           out_tap_EN;
  logic [DW-1:0]  out_tap_Di;
  logic [TNW-1:0] out_tap_A;
  logic [DW-1:0]  in_tap_Do;
  logic           in_core_tap_EN = 1'b0;
  logic [TNW-1:0] in_core_tap_A = '0;
  logic           in_core_done = 1'b0;
  logic           out_ap_start;
  logic [DW-1:0]  out_tap_num;
  logic [DW-1:0]  out_data_length;

  always #5 aclk = ~aclk;

  fir_axil_cfg #(
    .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .TAP_NUM(TN), .TAP_NUM_WIDTH(TNW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_s_awvalid(in_s_awvalid), .in_s_awaddr(in_s_awaddr), .out_s_awready(out_s_awready),
    .in_s_wvalid(in_s_wvalid), .in_s_wdata(in_s_wdata), .out_s_wready(out_s_wready),
    .in_s_arvalid(in_s_arvalid), .in_s_araddr(in_s_araddr), .out_s_arready(out_s_arready),
    .out_s_rvalid(out_s_rvalid), .out_s_rdata(out_s_rdata), .in_s_rready(in_s_rready),
    .out_tap_WE(out_tap_WE), .out_tap_EN(out_tap_EN), .out_tap_Di(out_tap_Di),
    .out_tap_A(out_tap_A), .in_tap_Do(in_tap_Do),
    .in_core_tap_EN(in_core_tap_EN), .in_core_tap_A(in_core_tap_A),
    .in_core_done(in_core_done), .out_ap_start(out_ap_start),
    .out_tap_num(out_tap_num), .out_data_length(out_data_length)
  );

  // Single-port tap RAM, read-first, one cycle read latency
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] tap_do = '0;
  assign in_tap_Do = tap_do;
  always @(posedge aclk) begin
    if (out_tap_EN) begin
      if (|out_tap_WE) ram[out_tap_A] <= out_tap_Di;
      tap_do <= ram[out_tap_A];
    end
  end

  // Event monitors
  int start_pulses = 0;
  int wr_strobes = 0;
  always @(negedge aclk) begin
    if (out_ap_start) start_pulses++;
    if (out_tap_EN && |out_tap_WE) wr_strobes++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural model of the config space
  logic [31:0] ref_mem [1024];
  logic [31:0] ref_tapnum, ref_dlen;
  bit          ref_idle, ref_done;
  int          exp_starts = 0;

  task automatic model_reset();
    ref_tapnum = '0;
    ref_dlen   = '0;
    ref_idle   = 1'b1;
    ref_done   = 1'b0;
  endtask

  function automatic bit tap_ok(input int unsigned idx);
`ifdef FIR_CFG_BOUNDS_CHECK_EN
    return (idx < TN) && (idx < ref_tapnum);
`else
    return idx < 1024;
`endif
  endfunction

  // Applies a write to the model; returns 1 if the tap RAM should be written
  function automatic bit model_write(input logic [31:0] addr, input logic [31:0] data, input bit done_now);
    int unsigned idx;
    bit ram_wr;
    idx = 32'(addr[TNW-1:0]);
    ram_wr = 1'b0;
    case (addr[31:28])
      4'h0: begin
        if (done_now) begin
          ref_done = 1'b1;
          ref_idle = 1'b1;
        end else if (data[0] && ref_idle) begin
          ref_idle = 1'b0;
          ref_done = 1'b0;
          exp_starts++;
        end
      end
      4'h1: if (ref_idle) ref_tapnum = data;
      4'h2: if (ref_idle) ref_dlen = data;
      4'h3: if (ref_idle && tap_ok(idx)) begin
        ref_mem[idx] = data;
        ram_wr = 1'b1;
      end
      default: ;
    endcase
    return ram_wr;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    logic [31:0] v;
    int unsigned idx;
    idx = 32'(addr[TNW-1:0]);
    v = '0;
    case (addr[31:28])
      4'h0: begin
        v[2] = ref_idle;
        v[1] = ref_done;
        ref_done = 1'b0;
      end
      4'h1: v = ref_tapnum;
      4'h2: v = ref_dlen;
      4'h3: if (ref_idle && tap_ok(idx)) v = ref_mem[idx];
      default: ;
    endcase
    return v;
  endfunction

  // Bus-level write; optionally pulses core_done in the ack cycle
  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data, input bit done_now);
    int cyc;
    @(negedge aclk);
    in_s_awaddr = addr;
    in_s_wdata = data;
    in_s_awvalid = 1'b1;
    in_s_wvalid = 1'b1;
    cyc = 0;
    do begin
      @(negedge aclk);
      cyc++;
    end while (!out_s_awready && cyc < 20);
    check("wr_ack", {out_s_awready, out_s_wready}, 32'h3);
    check("wr_ack_lat", cyc, 1);
    if (done_now) in_core_done = 1'b1;
    @(negedge aclk);
    in_core_done = 1'b0;
    in_s_awvalid = 1'b0;
    in_s_wvalid = 1'b0;
    check("wr_ack_1cyc", {out_s_awready, out_s_wready}, 32'h0);
  endtask

  task automatic axil_read(input logic [31:0] addr, input logic [31:0] exp, input int exp_lat, input int hold);
    int cyc;
    bit got_ar;
    @(negedge aclk);
    in_s_araddr = addr;
    in_s_arvalid = 1'b1;
    cyc = 0;
    got_ar = 1'b0;
    do begin
      @(negedge aclk);
      cyc++;
      if (got_ar) in_s_arvalid = 1'b0;
      if (out_s_arready) got_ar = 1'b1;
    end while (!out_s_rvalid && cyc < 20);
    in_s_arvalid = 1'b0;
    check($sformatf("rd_rvalid_%08h", addr), out_s_rvalid, 1);
    check($sformatf("rd_lat_%08h", addr), cyc, exp_lat);
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      check($sformatf("rd_hold_%08h", addr), {out_s_rvalid, out_s_rdata[30:0]}, {1'b1, exp[30:0]});
    end
    check($sformatf("rd_data_%08h", addr), out_s_rdata, exp);
    in_s_rready = 1'b1;
    @(negedge aclk);
    in_s_rready = 1'b0;
    check("rd_rvalid_clr", out_s_rvalid, 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input bit done_now = 1'b0);
    int s0;
    bit exp_wr;
    s0 = wr_strobes;
    exp_wr = model_write(addr, data, done_now);
    axil_write(addr, data, done_now);
    @(negedge aclk);
    check("ap_start_cnt", start_pulses, exp_starts);
    check("tap_wr_strobes", wr_strobes - s0, {31'b0, exp_wr});
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold = 0);
    logic [31:0] exp;
    exp = model_read(addr);
    axil_read(addr, exp, (addr[31:28] == 4'h3) ? 3 : 2, hold);
  endtask

  task automatic pulse_done();
    @(negedge aclk);
    in_core_done = 1'b1;
    @(negedge aclk);
    in_core_done = 1'b0;
    in_core_tap_EN = 1'b0;
    ref_done = 1'b1;
    ref_idle = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  int coef [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  initial begin
    int seen;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    model_reset();

    repeat (3) @(negedge aclk);
    check("rst_handshake", {out_s_awready, out_s_wready, out_s_arready, out_s_rvalid}, 0);
    check("rst_rdata", out_s_rdata, 0);
    check("rst_tap_en_we", {out_tap_EN, out_tap_WE}, 0);
    check("rst_tap_a", out_tap_A, 0);
    check("rst_tap_di", out_tap_Di, 0);
    check("rst_ap_start", out_ap_start, 0);
    check("rst_tap_num", out_tap_num, 0);
    check("rst_dlen", out_data_length, 0);
    aresetn = 1'b1;

    do_read(32'h0000_0000);
    do_read(32'h1000_0000);

    do_write(32'h1000_0000, 32'd11);
    do_write(32'h2000_0000, 32'd600);
    do_read(32'h1000_0000);
    do_read(32'h2000_0000);
    check("port_tap_num", out_tap_num, ref_tapnum);
    check("port_dlen", out_data_length, ref_dlen);

    for (int k = 0; k < 11; k++) do_write(32'h3000_0000 | 32'(k), 32'(coef[k]));
    for (int k = 0; k < 11; k++) do_read(32'h3000_0000 | 32'(k));
    do_read(32'h3000_0005, 4);

    // Start the core; it owns the tap port until done
    do_write(32'h0000_0000, 32'd1);
    in_core_tap_EN = 1'b1;
    in_core_tap_A = 10'd5;
    @(negedge aclk);
    check("busy_tap_a", out_tap_A, 5);
    check("busy_tap_en_we", {out_tap_EN, out_tap_WE}, 32'h10);
    do_read(32'h0000_0000);
    do_write(32'h3000_0002, 32'd99);
    check("busy_ram_kept", ram[2], ref_mem[2]);
    check("busy_tap_a_after", out_tap_A, 5);
    do_read(32'h3000_0002);
    do_write(32'h1000_0000, 32'd3);
    do_read(32'h1000_0000);
    do_write(32'h0000_0000, 32'd1);

    pulse_done();
    do_read(32'h0000_0000);
    do_read(32'h0000_0000);

    // Start again, then a start write colliding with core_done
    do_write(32'h0000_0000, 32'd1);
    in_core_tap_EN = 1'b1;
    do_write(32'h0000_0000, 32'd1, 1'b1);
    in_core_tap_EN = 1'b0;
    do_read(32'h0000_0000);
    do_read(32'h0000_0000);

    // Tap index beyond the physical depth / tap_num
    do_write(32'h3000_000C, 32'd5);
    do_read(32'h3000_000C);

    for (int n = 0; n < 40; n++) begin
      int unsigned op;
      op = $urandom_range(0, 5);
      case (op)
        0: do_write(32'h3000_0000 | 32'($urandom_range(0, 12)), $urandom);
        1: do_read(32'h3000_0000 | 32'($urandom_range(0, 12)), $urandom_range(0, 2));
        2: do_write(32'h1000_0000, 32'($urandom_range(5, 12)));
        3: do_write(32'h2000_0000, $urandom);
        4: do_read({4'($urandom_range(0, 2)), 28'($urandom)}, $urandom_range(0, 2));
        default: begin
          logic [31:0] a;
          a = {4'($urandom_range(4, 15)), 28'($urandom)};
          do_write(a, $urandom);
          do_read(a);
        end
      endcase
    end

    // Reset during a read: no rvalid may follow
    @(negedge aclk);
    in_s_araddr = 32'h1000_0000;
    in_s_arvalid = 1'b1;
    @(negedge aclk);
    aresetn = 1'b0;
    in_s_arvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      if (out_s_rvalid) seen++;
    end
    check("rst_mid_no_rvalid", seen, 0);
    do_read(32'h0000_0000);
    do_read(32'h1000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
